alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// Each operation runs IDLE -> EXEC -> RESP and is held in RESP until its owner takes the result.
module alu_arbiter #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_lop,
    input  logic [31:0] req0_rop,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_lop,
    input  logic [31:0] req1_rop,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [31:0] resp0_result,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    output logic [31:0] resp1_result,
    input  logic        resp1_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_served;
    logic        owner;
    logic [2:0]  op_q;
    logic [31:0] lop_q;
    logic [31:0] rop_q;
    logic [31:0] result_q;
    logic [31:0] alu_out;
    logic        grant0;
    logic        grant1;
    logic        accept0;
    logic        accept1;
    logic        resp_done;

    // On a tie the requester that was not served last wins; reset holds everyone off.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_served;
                grant1 = !last_served;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept0    = req0_valid & grant0;
    assign accept1    = req1_valid & grant1;

    // Only the owner's resp_ready can retire the held result.
    assign resp_done = (state == RESP) && (owner ? resp1_ready : resp0_ready);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept0 || accept1) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        alu_out = 32'h0;
        case (op_q)
            3'b000:  alu_out = lop_q + rop_q;
            3'b001:  alu_out = lop_q - rop_q;
            3'b010:  alu_out = lop_q & rop_q;
            3'b011:  alu_out = lop_q | rop_q;
            3'b100:  alu_out = (lop_q < rop_q) ? 32'h1 : 32'h0;
            default: alu_out = 32'h0;
        endcase
    end

    // Operands are captured once at acceptance so later input changes cannot disturb the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= !FIRST_PRIO;
            owner       <= 1'b0;
            op_q        <= 3'b000;
            lop_q       <= 32'h0;
            rop_q       <= 32'h0;
            result_q    <= 32'h0;
        end else begin
            if (accept0) begin
                owner       <= 1'b0;
                last_served <= 1'b0;
                op_q        <= req0_op;
                lop_q       <= req0_lop;
                rop_q       <= req0_rop;
            end else if (accept1) begin
                owner       <= 1'b1;
                last_served <= 1'b1;
                op_q        <= req1_op;
                lop_q       <= req1_lop;
                rop_q       <= req1_rop;
            end
            if (state == EXEC) begin
                result_q <= alu_out;
            end
        end
    end

    assign resp0_valid  = (state == RESP) && !owner;
    assign resp1_valid  = (state == RESP) && owner;
    assign resp0_result = resp0_valid ? result_q : 32'h0;
    assign resp1_result = resp1_valid ? result_q : 32'h0;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: reset, ALU ops, round-robin grants, backpressure and reset abort.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [2:0]  req0_op;
    logic [31:0] req0_lop;
    logic [31:0] req0_rop;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_op;
    logic [31:0] req1_lop;
    logic [31:0] req1_rop;
    logic        req1_ready;
    logic        resp0_valid;
    logic [31:0] resp0_result;
    logic        resp0_ready;
    logic        resp1_valid;
    logic [31:0] resp1_result;
    logic        resp1_ready;
    logic        busy;

    int assertions = 0;
    int failures   = 0;

    alu_arbiter #(.FIRST_PRIO(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_op      (req0_op),
        .req0_lop     (req0_lop),
        .req0_rop     (req0_rop),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_op      (req1_op),
        .req1_lop     (req1_lop),
        .req1_rop     (req1_rop),
        .req1_ready   (req1_ready),
        .resp0_valid  (resp0_valid),
        .resp0_result (resp0_result),
        .resp0_ready  (resp0_ready),
        .resp1_valid  (resp1_valid),
        .resp1_result (resp1_result),
        .resp1_ready  (resp1_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit id, input logic valid, input logic [2:0] op,
                                 input logic [31:0] lop, input logic [31:0] rop);
        if (id) begin
            req1_valid = valid; req1_op = op; req1_lop = lop; req1_rop = rop;
        end else begin
            req0_valid = valid; req0_op = op; req0_lop = lop; req0_rop = rop;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Single-requester operation from IDLE through the response handshake.
    task automatic runOp(input string tag, input bit id, input logic [2:0] op,
                         input logic [31:0] lop, input logic [31:0] rop, input logic [31:0] exp);
        applyStimulus(id, 1'b1, op, lop, rop);
        #1;
        checkOutput({tag, " ready"}, {30'h0, req1_ready, req0_ready}, id ? 32'h2 : 32'h1);
        tick();
        applyStimulus(id, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checkOutput({tag, " exec busy/ready/valid"},
                    {27'h0, busy, req1_ready, req0_ready, resp1_valid, resp0_valid}, 32'h10);
        tick();
        checkOutput({tag, " resp valid"}, {30'h0, resp1_valid, resp0_valid}, id ? 32'h2 : 32'h1);
        checkOutput({tag, " result"}, id ? resp1_result : resp0_result, exp);
        if (id) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        #1;
        checkOutput({tag, " back idle"}, {29'h0, busy, resp1_valid, resp0_valid}, 32'h0);
        checkOutput({tag, " results zero"}, resp0_result | resp1_result, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b000; req0_lop = 32'h0; req0_rop = 32'h0;
        req1_valid = 1'b1; req1_op = 3'b000; req1_lop = 32'h0; req1_rop = 32'h0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        tick();
        checkOutput("reset readies", {30'h0, req1_ready, req0_ready}, 32'h0);
        tick();
        checkOutput("reset busy/valids", {29'h0, busy, resp1_valid, resp0_valid}, 32'h0);
        checkOutput("reset results", resp0_result | resp1_result, 32'h0);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("idle no valid readies", {30'h0, req1_ready, req0_ready}, 32'h0);

        runOp("add wrap", 1'b0, 3'b000, 32'hFFFFFFFF, 32'h1, 32'h0);
        runOp("sltu 80000000<1", 1'b1, 3'b100, 32'h80000000, 32'h1, 32'h0);
        runOp("sltu 1<80000000", 1'b1, 3'b100, 32'h1, 32'h80000000, 32'h1);
        runOp("op111", 1'b0, 3'b111, 32'h5, 32'h7, 32'h0);
        runOp("op101", 1'b1, 3'b101, 32'h5, 32'h7, 32'h0);
        runOp("sub 5-7", 1'b0, 3'b001, 32'h5, 32'h7, 32'hFFFFFFFE);
        runOp("and", 1'b1, 3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        runOp("or", 1'b0, 3'b011, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11);

        // Both requesters held valid from reset: grants must alternate 0,1,0,1.
        doReset();
        applyStimulus(1'b0, 1'b1, 3'b000, 32'd10, 32'd20);
        applyStimulus(1'b1, 1'b1, 3'b001, 32'd100, 32'd1);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("rr grant", {30'h0, req1_ready, req0_ready}, (i % 2) ? 32'h2 : 32'h1);
            tick();
            checkOutput("rr exec readies", {30'h0, req1_ready, req0_ready}, 32'h0);
            tick();
            checkOutput("rr resp route", {30'h0, resp1_valid, resp0_valid}, (i % 2) ? 32'h2 : 32'h1);
            checkOutput("rr result", (i % 2) ? resp1_result : resp0_result, (i % 2) ? 32'd99 : 32'd30);
            tick();
        end

        // Backpressure on requester 0 while requester 1 waits.
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        #1;
        checkOutput("bp grant0", {30'h0, req1_ready, req0_ready}, 32'h1);
        tick();
        req0_lop = 32'd999;
        resp1_ready = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp resp0 valid", {31'h0, resp0_valid}, 32'h1);
            checkOutput("bp resp0 result", resp0_result, 32'd30);
            checkOutput("bp req1 ready", {31'h0, req1_ready}, 32'h0);
            tick();
        end
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        #1;
        checkOutput("bp grant1 after handshake", {30'h0, req1_ready, req0_ready}, 32'h2);
        req0_valid = 1'b0;
        tick();
        req1_valid = 1'b0;
        tick();
        checkOutput("bp resp1 result", resp1_result, 32'd99);
        tick();
        resp1_ready = 1'b0;
        #1;
        checkOutput("bp idle", {31'h0, busy}, 32'h0);

        // Reset during EXEC aborts the operation.
        applyStimulus(1'b0, 1'b1, 3'b000, 32'd3, 32'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checkOutput("abort exec busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("abort idle", {29'h0, busy, resp1_valid, resp0_valid}, 32'h0);
        tick();
        tick();
        checkOutput("abort no resp", {29'h0, busy, resp1_valid, resp0_valid}, 32'h0);
        runOp("after abort", 1'b0, 3'b000, 32'd3, 32'd4, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
